// File: rtl/uarch_pkg.sv
// -----------------------------------------------------------------------------
// uarch_pkg -- shared micro-architecture types and defaults for the reorder
// buffer slice.
//
// Contents:
//   DEF_ROB_DEPTH / DEF_ALLOC_W / DEF_COMMIT_W / DEF_CDB_W  default sizes
//   TAG_WIDTH                 ROB tag width for the default depth
//   rob_entry_t               one ROB slot (control flags, pc, dest, result)
//   writeback_packet_t        one CDB broadcast
//   prf_commit_write_port_t   one in-order register-file commit write
//   redirect_target()         control-flow target with bit 0 forced low
// -----------------------------------------------------------------------------
package uarch_pkg;

    localparam int DEF_ROB_DEPTH = 32;
    localparam int DEF_ALLOC_W   = 2;
    localparam int DEF_COMMIT_W  = 2;
    localparam int DEF_CDB_W     = 2;

    localparam int TAG_WIDTH      = $clog2(DEF_ROB_DEPTH);
    localparam int CPU_ADDR_BITS  = 32;
    localparam int XLEN           = 32;
    localparam int REG_ADDR_BITS  = 5;

    typedef struct packed {
        logic                     is_valid;
        logic                     is_ready;
        logic                     has_exception;
        logic                     is_branch;
        logic                     is_jump;
        logic                     is_store;
        logic                     has_rd;
        logic [REG_ADDR_BITS-1:0] rd;
        logic [CPU_ADDR_BITS-1:0] pc;
        logic [XLEN-1:0]          result;
    } rob_entry_t;

    typedef struct packed {
        logic                 is_valid;
        logic [TAG_WIDTH-1:0] dest_tag;
        logic [XLEN-1:0]      result;
        logic                 has_exception;
    } writeback_packet_t;

    typedef struct packed {
        logic                     we;
        logic [REG_ADDR_BITS-1:0] addr;
        logic [XLEN-1:0]          data;
    } prf_commit_write_port_t;

    // Branch and jump results carry the resolved target; bit 0 of a branch
    // result doubles as its mispredict flag, so it is never part of the pc.
    function automatic logic [CPU_ADDR_BITS-1:0] redirect_target(input logic [XLEN-1:0] result);
        return {result[CPU_ADDR_BITS-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// -----------------------------------------------------------------------------
// rob_commit_sel -- combinational retirement selection over the COMMIT_W
// oldest ROB slots.
//
// Ports:
//   slot_entry[k]     entry at head+k (is_valid already resolved)
//   slot_avail[k]     k < occupancy
//   slot_tag[k]       tag of head+k
//   lsq_store_rdy     LSQ can accept a store release this cycle
//   trap_vec          exception redirect target
//   commit_port[k]    register commit for slot k (all zero when idle)
//   retire[k]         slot k leaves the ROB this cycle
//   store_commit_*    single store release
//   flush/redirect_pc oldest flush source of this cycle
//   exc_taken/exc_pc  flush is an exception; its faulting pc
// -----------------------------------------------------------------------------
module rob_commit_sel
    import uarch_pkg::*;
#(
    parameter int COMMIT_W = DEF_COMMIT_W
) (
    input  rob_entry_t               slot_entry [COMMIT_W],
    input  logic [COMMIT_W-1:0]      slot_avail,
    input  logic [TAG_WIDTH-1:0]     slot_tag   [COMMIT_W],
    input  logic                     lsq_store_rdy,
    input  logic [CPU_ADDR_BITS-1:0] trap_vec,
    output prf_commit_write_port_t   commit_port [COMMIT_W],
    output logic [COMMIT_W-1:0]      retire,
    output logic                     store_commit_val,
    output logic [TAG_WIDTH-1:0]     store_commit_id,
    output logic                     flush,
    output logic [CPU_ADDR_BITS-1:0] redirect_pc,
    output logic                     exc_taken,
    output logic [CPU_ADDR_BITS-1:0] exc_pc
);

    logic blocked;     // an older slot stalled or raised a flush
    logic store_used;  // the single store release is already taken

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path can
        // leave a value held over from the previous evaluation (no latches).
        blocked          = 1'b0;
        store_used       = 1'b0;
        retire           = '0;
        store_commit_val = 1'b0;
        store_commit_id  = '0;
        flush            = 1'b0;
        redirect_pc      = '0;
        exc_taken        = 1'b0;
        exc_pc           = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            commit_port[k] = '0;
            if (blocked || !slot_avail[k] || !slot_entry[k].is_valid || !slot_entry[k].is_ready) begin
                blocked = 1'b1;
            end else if (slot_entry[k].has_exception) begin
                flush       = 1'b1;
                redirect_pc = trap_vec;
                exc_taken   = 1'b1;
                exc_pc      = slot_entry[k].pc;
                blocked     = 1'b1;
            end else if (slot_entry[k].is_branch && slot_entry[k].result[0]) begin
                flush       = 1'b1;
                redirect_pc = redirect_target(slot_entry[k].result);
                blocked     = 1'b1;
            end else if (slot_entry[k].is_store) begin
                // A store that cannot be released holds back every younger slot.
                if (lsq_store_rdy && !store_used) begin
                    retire[k]        = 1'b1;
                    store_used       = 1'b1;
                    store_commit_val = 1'b1;
                    store_commit_id  = slot_tag[k];
                end else begin
                    blocked = 1'b1;
                end
            end else begin
                retire[k] = 1'b1;
                if (slot_entry[k].has_rd) begin
                    commit_port[k].we   = 1'b1;
                    commit_port[k].addr = slot_entry[k].rd;
                    commit_port[k].data = slot_entry[k].is_jump ? XLEN'(slot_entry[k].pc + 32'd4)
                                                                : slot_entry[k].result;
                end
                // A jump writes its link register and then redirects fetch.
                if (slot_entry[k].is_jump) begin
                    flush       = 1'b1;
                    redirect_pc = redirect_target(slot_entry[k].result);
                    blocked     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rob_mw.sv
// -----------------------------------------------------------------------------
// rob_mw -- multi-wide reorder buffer: ALLOC_W allocations, CDB_W writeback
// snoops and COMMIT_W in-order commits per cycle.
//
// Ports:
//   alloc_req/alloc_gnt/alloc_tag  contiguous allocation grants and tags
//   rob_we/rob_entry               dispatch writes at alloc_tag
//   rob_rdy                        bit i: at least i+1 free entries
//   cdb                            result broadcasts
//   commit_port                    in-order register commits
//   store_commit_val/id, lsq_store_rdy  store release handshake
//   trap_vec                       exception target
//   flush/redirect_pc              pipeline flush and fetch target
//   epc/epc_val                    faulting pc, one-cycle pulse
//   rob_head/rob_tail/rob_count    pointers and occupancy
// -----------------------------------------------------------------------------
module rob_mw
    import uarch_pkg::*;
#(
    parameter int ROB_DEPTH = DEF_ROB_DEPTH,
    parameter int ALLOC_W   = DEF_ALLOC_W,
    parameter int COMMIT_W  = DEF_COMMIT_W,
    parameter int CDB_W     = DEF_CDB_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ALLOC_W-1:0]         alloc_req,
    output logic [ALLOC_W-1:0]         alloc_gnt,
    output logic [TAG_WIDTH-1:0]       alloc_tag [ALLOC_W],
    input  logic [ALLOC_W-1:0]         rob_we,
    input  rob_entry_t                 rob_entry [ALLOC_W],
    output logic [ALLOC_W-1:0]         rob_rdy,
    input  writeback_packet_t          cdb [CDB_W],
    output prf_commit_write_port_t     commit_port [COMMIT_W],
    output logic                       store_commit_val,
    output logic [TAG_WIDTH-1:0]       store_commit_id,
    input  logic                       lsq_store_rdy,
    input  logic [CPU_ADDR_BITS-1:0]   trap_vec,
    output logic                       flush,
    output logic [CPU_ADDR_BITS-1:0]   redirect_pc,
    output logic [CPU_ADDR_BITS-1:0]   epc,
    output logic                       epc_val,
    output logic [TAG_WIDTH-1:0]       rob_head,
    output logic [TAG_WIDTH-1:0]       rob_tail,
    output logic [$clog2(ROB_DEPTH):0] rob_count
);

    localparam int IDX_W = $clog2(ROB_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef logic [IDX_W-1:0] idx_t;

    logic [PTR_W-1:0]     head_q, tail_q, count_q;
    logic [PTR_W-1:0]     free, we_cnt, commit_cnt;
    logic [ROB_DEPTH-1:0] valid_q;
    rob_entry_t           entry_q [ROB_DEPTH];

    idx_t                 wr_idx  [ALLOC_W];
    idx_t                 rd_idx  [COMMIT_W];
    idx_t                 cdb_idx [CDB_W];
    rob_entry_t           slot_entry [COMMIT_W];
    logic [TAG_WIDTH-1:0] slot_tag   [COMMIT_W];
    logic [COMMIT_W-1:0]  slot_avail, retire;
    logic                 exc_taken;
    logic [CPU_ADDR_BITS-1:0] exc_pc;
    logic                 chain;

    // Occupancy is tracked explicitly, so full and empty never need a
    // pointer comparison.
    assign free = PTR_W'(ROB_DEPTH) - count_q;

    always_comb begin
        chain = 1'b1;
        for (int i = 0; i < ALLOC_W; i++) begin
            wr_idx[i]    = tail_q[IDX_W-1:0] + idx_t'(i);
            alloc_tag[i] = TAG_WIDTH'(wr_idx[i]);
            rob_rdy[i]   = int'(free) > i;
            // Grants form a prefix: a slot is granted only if all lower slots are.
            chain        = chain & alloc_req[i] & rob_rdy[i];
            alloc_gnt[i] = chain;
        end
    end

    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            rd_idx[k]              = head_q[IDX_W-1:0] + idx_t'(k);
            slot_entry[k]          = entry_q[rd_idx[k]];
            slot_entry[k].is_valid = valid_q[rd_idx[k]];
            slot_tag[k]            = TAG_WIDTH'(rd_idx[k]);
            slot_avail[k]          = int'(count_q) > k;
        end
    end

    always_comb begin
        for (int p = 0; p < CDB_W; p++) begin
            cdb_idx[p] = idx_t'(cdb[p].dest_tag);
        end
    end

    always_comb begin
        we_cnt     = '0;
        commit_cnt = '0;
        for (int i = 0; i < ALLOC_W; i++) we_cnt = we_cnt + PTR_W'(rob_we[i]);
        for (int k = 0; k < COMMIT_W; k++) commit_cnt = commit_cnt + PTR_W'(retire[k]);
    end

    rob_commit_sel #(
        .COMMIT_W (COMMIT_W)
    ) u_commit_sel (
        .slot_entry       (slot_entry),
        .slot_avail       (slot_avail),
        .slot_tag         (slot_tag),
        .lsq_store_rdy    (lsq_store_rdy),
        .trap_vec         (trap_vec),
        .commit_port      (commit_port),
        .retire           (retire),
        .store_commit_val (store_commit_val),
        .store_commit_id  (store_commit_id),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .exc_taken        (exc_taken),
        .exc_pc           (exc_pc)
    );

    // Control state: pointers, occupancy, valid bits and the epc pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            epc     <= '0;
            epc_val <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // read in this block sees the pre-edge value, as the comb logic does.
            epc_val <= exc_taken;
            if (exc_taken) epc <= exc_pc;
            if (flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                valid_q <= '0;
            end else begin
                head_q  <= head_q + commit_cnt;
                tail_q  <= tail_q + we_cnt;
                count_q <= count_q + we_cnt - commit_cnt;
                for (int k = 0; k < COMMIT_W; k++) begin
                    if (retire[k]) valid_q[rd_idx[k]] <= 1'b0;
                end
                for (int i = 0; i < ALLOC_W; i++) begin
                    if (rob_we[i]) valid_q[wr_idx[i]] <= 1'b1;
                end
            end
        end
    end

    // NOTE: the payload array has no reset; only the valid bits need a
    // defined value, and a reset-free array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (!flush) begin
            // Later ports overwrite earlier ones, so the highest port wins.
            for (int p = 0; p < CDB_W; p++) begin
                if (cdb[p].is_valid && valid_q[cdb_idx[p]]) begin
                    entry_q[cdb_idx[p]].is_ready      <= 1'b1;
                    entry_q[cdb_idx[p]].result        <= cdb[p].result;
                    entry_q[cdb_idx[p]].has_exception <= cdb[p].has_exception;
                end
            end
            // Dispatch targets free entries, which no valid CDB hit can touch.
            for (int i = 0; i < ALLOC_W; i++) begin
                if (rob_we[i]) entry_q[wr_idx[i]] <= rob_entry[i];
            end
        end
    end

    assign rob_head  = TAG_WIDTH'(head_q[IDX_W-1:0]);
    assign rob_tail  = TAG_WIDTH'(tail_q[IDX_W-1:0]);
    assign rob_count = count_q;

endmodule

// File: tb/tb_rob_mw.sv
module tb_rob_mw;
    import uarch_pkg::*;

    localparam int D  = DEF_ROB_DEPTH;
    localparam int AW = DEF_ALLOC_W;
    localparam int CW = DEF_COMMIT_W;
    localparam int PW = DEF_CDB_W;

    localparam int K_ALU = 0, K_STORE = 1, K_BRANCH = 2, K_JUMP = 3, K_ALU_NORD = 4;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [AW-1:0]              alloc_req, alloc_gnt, rob_we, rob_rdy;
    logic [TAG_WIDTH-1:0]       alloc_tag [AW];
    rob_entry_t                 rob_entry [AW];
    writeback_packet_t          cdb [PW];
    prf_commit_write_port_t     commit_port [CW];
    logic                       store_commit_val, lsq_store_rdy, flush, epc_val;
    logic [TAG_WIDTH-1:0]       store_commit_id, rob_head, rob_tail;
    logic [CPU_ADDR_BITS-1:0]   trap_vec, redirect_pc, epc;
    logic [$clog2(D):0]         rob_count;

    always #5 clk = ~clk;

    rob_mw #(.ROB_DEPTH(D), .ALLOC_W(AW), .COMMIT_W(CW), .CDB_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
        .rob_we(rob_we), .rob_entry(rob_entry), .rob_rdy(rob_rdy),
        .cdb(cdb), .commit_port(commit_port),
        .store_commit_val(store_commit_val), .store_commit_id(store_commit_id),
        .lsq_store_rdy(lsq_store_rdy), .trap_vec(trap_vec),
        .flush(flush), .redirect_pc(redirect_pc),
        .epc(epc), .epc_val(epc_val),
        .rob_head(rob_head), .rob_tail(rob_tail), .rob_count(rob_count)
    );

    // Reference model: the ROB is an ordered queue of (tag, entry) records.
    typedef struct { int tag; rob_entry_t e; } m_ent_t;
    m_ent_t       m_q[$];
    int           m_head, m_tail;
    bit           m_epc_val;
    logic [31:0]  m_epc;

    logic [AW-1:0]          x_gnt, x_rdy;
    prf_commit_write_port_t x_cp [CW];
    bit                     x_st_val, x_flush, x_exc;
    int                     x_st_id, x_nret;
    logic [31:0]            x_redir, x_exc_pc;

    int n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    // Expected combinational outputs from the model state and current inputs.
    function automatic void predict();
        int free;
        bit chain, store_done;
        rob_entry_t e;
        free = D - m_q.size();
        chain = 1'b1;
        for (int i = 0; i < AW; i++) begin
            x_rdy[i] = free > i;
            chain    = chain && alloc_req[i] && (free > i);
            x_gnt[i] = chain;
        end
        x_flush = 0; x_redir = '0; x_nret = 0; x_exc = 0; x_exc_pc = '0;
        x_st_val = 0; x_st_id = 0; store_done = 0;
        for (int k = 0; k < CW; k++) x_cp[k] = '0;
        for (int k = 0; k < CW && k < m_q.size(); k++) begin
            e = m_q[k].e;
            if (!e.is_ready) break;
            if (e.has_exception) begin
                x_flush = 1; x_redir = trap_vec; x_exc = 1; x_exc_pc = e.pc;
                break;
            end
            if (e.is_branch && e.result[0]) begin
                x_flush = 1; x_redir = e.result & ~32'h1;
                break;
            end
            if (e.is_store) begin
                if (!lsq_store_rdy || store_done) break;
                store_done = 1; x_st_val = 1; x_st_id = m_q[k].tag; x_nret++;
                continue;
            end
            x_nret++;
            if (e.has_rd) begin
                x_cp[k].we   = 1'b1;
                x_cp[k].addr = e.rd;
                x_cp[k].data = e.is_jump ? e.pc + 32'd4 : e.result;
            end
            if (e.is_jump) begin
                x_flush = 1; x_redir = e.result & ~32'h1;
                break;
            end
        end
    endfunction

    task automatic compare();
        check("alloc_gnt", alloc_gnt, x_gnt);
        check("rob_rdy", rob_rdy, x_rdy);
        for (int i = 0; i < AW; i++) check($sformatf("alloc_tag%0d", i), alloc_tag[i], (m_tail + i) % D);
        for (int k = 0; k < CW; k++) check($sformatf("commit%0d", k), commit_port[k], x_cp[k]);
        check("store_val", store_commit_val, x_st_val);
        if (x_st_val) check("store_id", store_commit_id, x_st_id);
        check("flush", flush, x_flush);
        if (x_flush) check("redirect_pc", redirect_pc, x_redir);
        check("rob_head", rob_head, m_head);
        check("rob_tail", rob_tail, m_tail);
        check("rob_count", rob_count, m_q.size());
        check("epc_val", epc_val, m_epc_val);
        if (m_epc_val) check("epc", epc, m_epc);
    endtask

    // Model state change at the clock edge.
    task automatic update();
        m_ent_t n;
        m_epc_val = x_exc;
        if (x_exc) m_epc = x_exc_pc;
        if (x_flush) begin
            m_q.delete(); m_head = 0; m_tail = 0;
            return;
        end
        for (int p = 0; p < PW; p++) begin
            if (cdb[p].is_valid) begin
                foreach (m_q[j]) begin
                    if (m_q[j].tag == int'(cdb[p].dest_tag)) begin
                        m_q[j].e.is_ready      = 1'b1;
                        m_q[j].e.result        = cdb[p].result;
                        m_q[j].e.has_exception = cdb[p].has_exception;
                    end
                end
            end
        end
        repeat (x_nret) void'(m_q.pop_front());
        m_head = (m_head + x_nret) % D;
        for (int i = 0; i < AW; i++) begin
            if (rob_we[i]) begin
                n.tag = m_tail; n.e = rob_entry[i]; n.e.is_valid = 1'b1;
                m_q.push_back(n);
                m_tail = (m_tail + 1) % D;
            end
        end
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic cycle();
        predict();
        #1 compare();
        @(posedge clk);
        update();
        @(negedge clk);
    endtask

    function automatic rob_entry_t mk(input int kind);
        rob_entry_t e;
        e = '0;
        e.is_valid  = 1'b1;
        e.pc        = $urandom() & 32'hffff_fffc;
        e.rd        = REG_ADDR_BITS'($urandom_range(1, 31));
        e.has_rd    = (kind == K_ALU) || (kind == K_JUMP);
        e.is_store  = (kind == K_STORE);
        e.is_branch = (kind == K_BRANCH);
        e.is_jump   = (kind == K_JUMP);
        return e;
    endfunction

    task automatic wb(input int p, input int tag, input logic [31:0] res, input bit exc);
        cdb[p].is_valid      = 1'b1;
        cdb[p].dest_tag      = TAG_WIDTH'(tag);
        cdb[p].result        = res;
        cdb[p].has_exception = exc;
    endtask

    task automatic clear_inputs();
        alloc_req = '0; rob_we = '0; lsq_store_rdy = 1'b0; trap_vec = 32'h100;
        for (int i = 0; i < AW; i++) rob_entry[i] = '0;
        for (int p = 0; p < PW; p++) cdb[p] = '0;
    endtask

    task automatic dispatch(input logic [AW-1:0] req, input int k0, input int k1);
        alloc_req = req; rob_we = req;
        rob_entry[0] = mk(k0); rob_entry[1] = mk(k1);
    endtask

    initial begin
        logic [31:0] saved_pc;
        int pick, kind;
        bit found;

        rst_n = 1'b1;
        clear_inputs();
        m_head = 0; m_tail = 0; m_epc_val = 0; m_epc = '0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        alloc_req = 2'b11;
        #1;
        check("rst_gnt", alloc_gnt, 2'b11);
        check("rst_rdy", rob_rdy, 2'b11);
        check("rst_flush", flush, 1'b0);
        check("rst_count", rob_count, 0);
        check("rst_store_val", store_commit_val, 1'b0);
        check("rst_commit_we", {commit_port[1].we, commit_port[0].we}, 2'b00);
        check("rst_epc_val", epc_val, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        @(negedge clk);

        // Two allocations from reset.
        clear_inputs(); dispatch(2'b11, K_ALU, K_ALU);
        #1;
        check("a2_gnt", alloc_gnt, 2'b11);
        check("a2_tag0", alloc_tag[0], 0);
        check("a2_tag1", alloc_tag[1], 1);
        cycle();
        check("a2_count", rob_count, 2);

        // Fill to one below full, then ask for two.
        for (int n = 0; n < (D - 4) / 2; n++) begin
            clear_inputs(); dispatch(2'b11, K_ALU, K_ALU); cycle();
        end
        clear_inputs(); dispatch(2'b01, K_ALU, K_ALU); cycle();
        check("fill_count", rob_count, D - 1);
        clear_inputs(); dispatch(2'b11, K_ALU, K_ALU); rob_we = 2'b01;
        #1;
        check("nf_gnt", alloc_gnt, 2'b01);
        check("nf_rdy", rob_rdy, 2'b01);
        cycle();
        check("full_count", rob_count, D);
        check("full_rdy", rob_rdy, 2'b00);

        // Both head ALU entries become ready in one cycle, then commit together.
        clear_inputs(); wb(0, 0, $urandom(), 0); wb(1, 1, $urandom(), 0); cycle();
        clear_inputs();
        #1;
        check("dual_we", {commit_port[1].we, commit_port[0].we}, 2'b11);
        cycle();
        check("dual_count", rob_count, D - 2);
        check("dual_head", rob_head, 2);

        // Exception at head.
        clear_inputs(); wb(0, 2, $urandom(), 1); cycle();
        saved_pc = m_q[0].e.pc;
        clear_inputs();
        #1;
        check("exc_flush", flush, 1'b1);
        check("exc_redirect", redirect_pc, 32'h100);
        check("exc_no_commit", {commit_port[1].we, commit_port[0].we}, 2'b00);
        cycle();
        check("exc_count", rob_count, 0);
        check("exc_epc_val", epc_val, 1'b1);
        check("exc_epc", epc, saved_pc);

        // Two ready stores: one release per cycle, in order.
        clear_inputs(); dispatch(2'b11, K_STORE, K_STORE); cycle();
        clear_inputs(); wb(0, 0, $urandom(), 0); wb(1, 1, $urandom(), 0); cycle();
        clear_inputs(); lsq_store_rdy = 1'b1;
        #1;
        check("st1_val", store_commit_val, 1'b1);
        check("st1_id", store_commit_id, 0);
        cycle();
        clear_inputs(); lsq_store_rdy = 1'b1;
        #1;
        check("st2_val", store_commit_val, 1'b1);
        check("st2_id", store_commit_id, 1);
        cycle();
        clear_inputs(); dispatch(2'b01, K_STORE, K_ALU); cycle();
        clear_inputs(); wb(0, m_q[0].tag, $urandom(), 0); cycle();
        clear_inputs();
        #1;
        check("st_blocked", store_commit_val, 1'b0);
        cycle();
        check("st_blocked_count", rob_count, 1);
        clear_inputs(); lsq_store_rdy = 1'b1; cycle();

        // Walk the pointers to D-1 with an empty ROB.
        for (int n = 0; n < 4 * D; n++) begin
            if (m_q.size() == 0 && m_tail == D - 1) break;
            clear_inputs();
            if (m_tail != D - 1) dispatch(2'b01, K_ALU, K_ALU);
            found = 0;
            foreach (m_q[j]) begin
                if (!found && !m_q[j].e.is_ready) begin
                    wb(0, m_q[j].tag, $urandom(), 0); found = 1;
                end
            end
            cycle();
        end
        check("wrap_head", rob_head, D - 1);
        check("wrap_empty", rob_count, 0);
        clear_inputs(); dispatch(2'b11, K_ALU, K_BRANCH); cycle();
        check("wrap_tail", rob_tail, 1);
        clear_inputs(); wb(0, D - 1, $urandom(), 0); wb(1, 0, 32'h2001, 0); cycle();
        clear_inputs();
        #1;
        check("wrap_commit0", commit_port[0].we, 1'b1);
        check("wrap_commit1", commit_port[1].we, 1'b0);
        check("wrap_flush", flush, 1'b1);
        check("wrap_redirect", redirect_pc, 32'h2000);
        cycle();
        check("wrap_clear_head", rob_head, 0);
        check("wrap_clear_count", rob_count, 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            clear_inputs();
            alloc_req = AW'($urandom());
            predict();
            rob_we = x_gnt;
            if ($urandom_range(0, 3) == 0) rob_we = rob_we & 2'b01;
            for (int i = 0; i < AW; i++) begin
                pick = $urandom_range(0, 9);
                kind = (pick < 5) ? K_ALU : (pick == 5) ? K_ALU_NORD :
                       (pick < 8) ? K_STORE : (pick == 8) ? K_BRANCH : K_JUMP;
                rob_entry[i] = mk(kind);
            end
            for (int p = 0; p < PW; p++) begin
                if (m_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    pick = $urandom_range(0, m_q.size() - 1);
                    wb(p, m_q[pick].tag, $urandom(), $urandom_range(0, 39) == 0);
                    if ($urandom_range(0, 7) != 0) cdb[p].result[0] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    wb(p, $urandom_range(0, D - 1), $urandom() & 32'hffff_fffe, 0);
                end
            end
            if ($urandom_range(0, 7) == 0) cdb[1] = '{is_valid: 1'b1, dest_tag: cdb[0].dest_tag,
                                                        result: $urandom() & 32'hffff_fffe, has_exception: 1'b0};
            lsq_store_rdy = $urandom_range(0, 3) != 0;
            trap_vec = $urandom() & 32'hffff_fffc;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rob_mw.md
ROB_MW -- requirements
Module: rob_mw

Interface
REQ-001 Parameter ROB_DEPTH, default 32: entry count, power of two, >= 4.
REQ-002 Parameter ALLOC_W, default 2: allocation/dispatch slots per cycle, 1..4.
REQ-003 Parameter COMMIT_W, default 2: commit slots per cycle, 1..4.
REQ-004 Parameter CDB_W, default 2: CDB writeback ports snooped, 1..4.
REQ-005 clk  in  1  single clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 alloc_req / alloc_gnt  in / out  ALLOC_W  allocation request / grant per slot.
REQ-008 alloc_tag  out  ALLOC_W x TAG_WIDTH  tag for slot i, equal to tail+i modulo ROB_DEPTH.
REQ-009 rob_we  in  ALLOC_W  dispatch write enables; rob_entry  in  ALLOC_W x rob_entry_t  entries written at alloc_tag[i].
REQ-010 rob_rdy  out  ALLOC_W  bit i high when free >= i+1.
REQ-011 cdb  in  CDB_W x writeback_packet_t  result broadcasts.
REQ-012 commit_port  out  COMMIT_W x prf_commit_write_port_t  in-order register commits.
REQ-013 store_commit_val / store_commit_id  out  1 / TAG_WIDTH  store release to LSQ; lsq_store_rdy  in  1  LSQ accepts release this cycle.
REQ-014 trap_vec  in  CPU_ADDR_BITS  exception redirect target.
REQ-015 flush / redirect_pc  out  1 / CPU_ADDR_BITS  pipeline flush and fetch target.
REQ-016 epc / epc_val  out  CPU_ADDR_BITS / 1  faulting PC, registered, pulse one cycle.
REQ-017 rob_head, rob_tail  out  TAG_WIDTH each; rob_count  out  clog2(ROB_DEPTH)+1  occupancy.

Function
REQ-018 Occupancy held in a count register; free = ROB_DEPTH - count; no pointer-compare full/empty.
REQ-019 alloc_gnt[i] = alloc_req[i] && alloc_gnt[i-1] (i>0) && free >= i+1; grants always contiguous from slot 0.
REQ-020 rob_we shall be a contiguous prefix (we[i] implies we[j], j<i); writes entry with is_valid=1, is_ready=0 semantics from rob_entry.
REQ-021 tail_next = tail + popcount(rob_we); head_next = head + commit count; count_next = count + popcount(rob_we) - commit count, all same edge.
REQ-022 CDB snoop: port p with is_valid and dest_tag==k and entry k valid sets is_ready, result, has_exception; higher port index wins on identical tag.
REQ-023 Commit slot k (head+k) fires iff entry valid and ready, slots 0..k-1 fired, no flush raised by slots 0..k-1, k < count.
REQ-024 Store slot additionally requires lsq_store_rdy and no earlier store committed this cycle; at most one store release per cycle; blocked store stalls itself and all younger slots.
REQ-025 Exception entry: no commit, flush=1, redirect_pc=trap_vec, epc=entry.pc captured next edge with epc_val pulse.
REQ-026 Mispredicted branch (is_branch && result[0]): no register commit, flush=1, redirect_pc={result[31:1],1'b0}.
REQ-027 Jump: commits rd=pc+4 then flush=1, redirect_pc={result[31:1],1'b0}.
REQ-028 Only the oldest flush source per cycle drives redirect_pc; younger slots produce no commit or store release.
REQ-029 flush and redirect_pc combinational from current state; on the edge where flush=1 head, tail, count clear and all is_valid clear; same-cycle rob_we and CDB writes discarded.
REQ-030 Non-committing commit_port slots drive we=0 and all-zero fields.
REQ-031 Pointers TAG_WIDTH+1 bits; wrap-around modulo ROB_DEPTH transparent to allocation, snoop and commit.

Reset
REQ-032 rst_n low asynchronously clears head, tail, count, all is_valid, epc, epc_val; payload fields not reset.
REQ-033 During and after reset: flush=0, commit we=0, store_commit_val=0, alloc_gnt follows alloc_req (free=ROB_DEPTH), rob_rdy all ones.

Structure
REQ-034 ROB_DEPTH/ALLOC_W/COMMIT_W/CDB_W defaults, rob_entry_t, writeback_packet_t, prf_commit_write_port_t, TAG_WIDTH live in uarch_pkg.
REQ-035 One sub-module rob_commit_sel: combinational per-slot commit/flush/store selection across COMMIT_W candidates.

Verification
REQ-036 Reset, request 2 allocations -> gnt=2'b11, tags 0,1; count=2 next cycle.
REQ-037 Fill to ROB_DEPTH-1, alloc_req=2'b11 -> gnt=2'b01, rob_rdy=2'b01; after write count=ROB_DEPTH, rob_rdy=0.
REQ-038 Head two ALU entries ready, CDB writes both same cycle -> next cycle both commit_port we=1, count drops by 2, head+2.
REQ-039 Two stores at head ready, lsq_store_rdy=1 -> one release id=head; next cycle second; lsq_store_rdy=0 -> no commit.
REQ-040 Slot 0 exception, trap_vec=0x100 -> flush=1, redirect_pc=0x100, no commits; next cycle count=0, epc_val=1, epc=entry pc.
REQ-041 Head at ROB_DEPTH-1, branch result=0x2001 in slot 1 after ALU slot 0 -> slot 0 commits, flush, redirect_pc=0x2000, pointers wrap then clear.
